// File: rtl/hazard_control_unit.sv
// Pipeline hazard unit: operand forwarding, load-use/store stall sequencing,
// branch flush sequencing and RAM address steering.
module hazard_control_unit #(
    parameter int DATA_W       = 32,
    parameter int REG_AW       = 5,
    parameter int LOAD_STALL   = 1,
    parameter int STORE_STALL  = 1,
    parameter int FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_srcA,
    input  logic [REG_AW-1:0] id_srcB,
    input  logic              id_valid,
    input  logic [1:0]        modein,
    input  logic [REG_AW-1:0] ex_dst,
    input  logic              ex_wen,
    input  logic              ex_is_load,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [REG_AW-1:0] mem_dst,
    input  logic              mem_wen,
    input  logic [DATA_W-1:0] mem_result,
    input  logic              store,
    input  logic [DATA_W-1:0] ram_rd_addr,
    input  logic [DATA_W-1:0] ram_wr_addr,
    input  logic              branch,
    output logic [1:0]        modeA,
    output logic [1:0]        modeB,
    output logic [DATA_W-1:0] fwdA,
    output logic [DATA_W-1:0] fwdB,
    output logic              stall,
    output logic              flush,
    output logic [DATA_W-1:0] ram_addr
);

    localparam int MAXP = (LOAD_STALL > STORE_STALL)
                        ? ((LOAD_STALL > FLUSH_CYCLES) ? LOAD_STALL : FLUSH_CYCLES)
                        : ((STORE_STALL > FLUSH_CYCLES) ? STORE_STALL : FLUSH_CYCLES);
    localparam int CW = ($clog2(MAXP) < 1) ? 1 : $clog2(MAXP);

    localparam logic [CW-1:0] FL_INIT = CW'(FLUSH_CYCLES > 1 ? FLUSH_CYCLES - 2 : 0);
    localparam logic [CW-1:0] ST_INIT = CW'(STORE_STALL > 1 ? STORE_STALL - 2 : 0);
    localparam logic [CW-1:0] LD_INIT = CW'(LOAD_STALL > 1 ? LOAD_STALL - 2 : 0);

    typedef enum logic [1:0] {IDLE, LSTALL, SSTALL, FLUSH} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;

    logic ex_hit_a, mem_hit_a, ex_hit_b, mem_hit_b, load_use;

    always_comb begin
        ex_hit_a  = id_valid && (id_srcA != '0) && ex_wen
                    && (ex_dst == id_srcA) && !ex_is_load;
        mem_hit_a = id_valid && (id_srcA != '0) && mem_wen && (mem_dst == id_srcA);
        ex_hit_b  = id_valid && (id_srcB != '0) && ex_wen
                    && (ex_dst == id_srcB) && !ex_is_load;
        mem_hit_b = id_valid && (id_srcB != '0) && mem_wen && (mem_dst == id_srcB);
        load_use  = id_valid && ex_wen && ex_is_load && (ex_dst != '0)
                    && ((ex_dst == id_srcA) || (ex_dst == id_srcB));
    end

    // EX has priority over MEM; a load in EX never forwards.
    always_comb begin
        modeA = 2'b00;
        fwdA  = '0;
        if (ex_hit_a) begin
            modeA = 2'b01;
            fwdA  = ex_result;
        end else if (mem_hit_a) begin
            modeA = 2'b10;
            fwdA  = mem_result;
        end
        modeB = modein;
        fwdB  = '0;
        if (ex_hit_b) begin
            modeB = 2'b11;
            fwdB  = ex_result;
        end else if (mem_hit_b) begin
            modeB = 2'b11;
            fwdB  = mem_result;
        end
    end

    always_comb begin
        stall    = 1'b0;
        flush    = 1'b0;
        ram_addr = ram_rd_addr;
        state_n  = state;
        cnt_n    = cnt;
        unique case (state)
            IDLE: begin
                if (branch) begin
                    flush = 1'b1;
                    if (FLUSH_CYCLES > 1) begin
                        state_n = FLUSH;
                        cnt_n   = FL_INIT;
                    end
                end else if (store) begin
                    stall    = 1'b1;
                    ram_addr = ram_wr_addr;
                    if (STORE_STALL > 1) begin
                        state_n = SSTALL;
                        cnt_n   = ST_INIT;
                    end
                end else if (load_use) begin
                    stall = 1'b1;
                    if (LOAD_STALL > 1) begin
                        state_n = LSTALL;
                        cnt_n   = LD_INIT;
                    end
                end
            end
            LSTALL, SSTALL: begin
                // A taken branch abandons the stall and starts a fresh flush.
                if (branch) begin
                    flush   = 1'b1;
                    state_n = (FLUSH_CYCLES > 1) ? FLUSH : IDLE;
                    cnt_n   = FL_INIT;
                end else begin
                    stall = 1'b1;
                    if (state == SSTALL)
                        ram_addr = ram_wr_addr;
                    if (cnt == '0)
                        state_n = IDLE;
                    else
                        cnt_n = cnt - CW'(1);
                end
            end
            FLUSH: begin
                flush = 1'b1;
                if (cnt == '0)
                    state_n = IDLE;
                else
                    cnt_n = cnt - CW'(1);
            end
            default: state_n = IDLE;
        endcase
        if (rst) begin
            stall = 1'b0;
            flush = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// Scoreboard bench for hazard_control_unit: directed stimulus pushes expected
// outputs, an independent monitor pops and compares each cycle.
module tb_hazard_control_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_srcA, id_srcB, ex_dst, mem_dst;
    logic        id_valid, ex_wen, ex_is_load, mem_wen, store, branch;
    logic [1:0]  modein;
    logic [31:0] ex_result, mem_result, ram_rd_addr, ram_wr_addr;
    logic [1:0]  modeA, modeB;
    logic [31:0] fwdA, fwdB, ram_addr;
    logic        stall, flush;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string       name;
        logic        st;
        logic        fl;
        logic [1:0]  ma;
        logic [1:0]  mb;
        logic [31:0] fa;
        logic [31:0] fb;
        logic [31:0] ra;
    } exp_t;

    exp_t q[$];

    hazard_control_unit #(
        .DATA_W(32), .REG_AW(5), .LOAD_STALL(2),
        .STORE_STALL(3), .FLUSH_CYCLES(2)
    ) dut (
        .clk(clk), .rst(rst),
        .id_srcA(id_srcA), .id_srcB(id_srcB), .id_valid(id_valid),
        .modein(modein),
        .ex_dst(ex_dst), .ex_wen(ex_wen), .ex_is_load(ex_is_load),
        .ex_result(ex_result),
        .mem_dst(mem_dst), .mem_wen(mem_wen), .mem_result(mem_result),
        .store(store), .ram_rd_addr(ram_rd_addr), .ram_wr_addr(ram_wr_addr),
        .branch(branch),
        .modeA(modeA), .modeB(modeB), .fwdA(fwdA), .fwdB(fwdB),
        .stall(stall), .flush(flush), .ram_addr(ram_addr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input string f,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", n, f, act, exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, "stall", 32'(stall), 32'(e.st));
                chk(e.name, "flush", 32'(flush), 32'(e.fl));
                chk(e.name, "modeA", 32'(modeA), 32'(e.ma));
                chk(e.name, "modeB", 32'(modeB), 32'(e.mb));
                chk(e.name, "fwdA", fwdA, e.fa);
                chk(e.name, "fwdB", fwdB, e.fb);
                chk(e.name, "ram_addr", ram_addr, e.ra);
            end
        end
    end

    task automatic expect_out(input string n, input logic st, input logic fl,
                              input logic [1:0] ma, input logic [1:0] mb,
                              input logic [31:0] fa, input logic [31:0] fb,
                              input logic [31:0] ra);
        exp_t e;
        e.name = n; e.st = st; e.fl = fl; e.ma = ma; e.mb = mb;
        e.fa = fa; e.fb = fb; e.ra = ra;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_fwd();
        id_srcA = 0; id_srcB = 0; id_valid = 1'b0;
        ex_dst = 0; ex_wen = 1'b0; ex_is_load = 1'b0; ex_result = 0;
        mem_dst = 0; mem_wen = 1'b0; mem_result = 0;
    endtask

    localparam logic [31:0] RD = 32'h100;
    localparam logic [31:0] WR = 32'h200;

    initial begin : stim
        rst = 1'b1;
        clear_fwd();
        modein = 2'b01; store = 1'b0; branch = 1'b0;
        ram_rd_addr = RD; ram_wr_addr = WR;
        tick();
        expect_out("reset", 0, 0, 2'b00, 2'b01, 0, 0, RD);
        tick();
        rst = 1'b0;

        // EX beats MEM for the same register
        id_valid = 1; id_srcA = 3;
        ex_wen = 1; ex_dst = 3; ex_result = 32'hAA;
        mem_wen = 1; mem_dst = 3; mem_result = 32'h33;
        expect_out("fwdA_ex", 0, 0, 2'b01, 2'b01, 32'hAA, 0, RD);
        tick();
        ex_dst = 4;
        expect_out("fwdA_mem", 0, 0, 2'b10, 2'b01, 32'h33, 0, RD);
        tick();

        clear_fwd();
        id_valid = 1; id_srcB = 5; mem_wen = 1; mem_dst = 5; mem_result = 32'h55;
        expect_out("fwdB_mem", 0, 0, 2'b00, 2'b11, 0, 32'h55, RD);
        tick();
        id_srcB = 0; mem_dst = 0;
        expect_out("fwdB_r0", 0, 0, 2'b00, 2'b01, 0, 0, RD);
        tick();
        id_srcB = 5; mem_dst = 5; id_valid = 0;
        expect_out("fwd_invalid", 0, 0, 2'b00, 2'b01, 0, 0, RD);
        tick();

        // load-use: two stall cycles, never forwarded from EX
        clear_fwd();
        id_valid = 1; id_srcA = 7;
        ex_wen = 1; ex_is_load = 1; ex_dst = 7; ex_result = 32'h77;
        expect_out("lu_c1", 1, 0, 2'b00, 2'b01, 0, 0, RD);
        tick();
        expect_out("lu_c2", 1, 0, 2'b00, 2'b01, 0, 0, RD);
        tick();
        ex_wen = 0; ex_is_load = 0; mem_wen = 1; mem_dst = 7; mem_result = 32'h77;
        expect_out("lu_done", 0, 0, 2'b10, 2'b01, 32'h77, 0, RD);
        tick();

        // store: three stall cycles on the write address
        clear_fwd();
        store = 1;
        expect_out("st_c1", 1, 0, 2'b00, 2'b01, 0, 0, WR);
        tick();
        store = 0;
        id_valid = 1; id_srcB = 5; mem_wen = 1; mem_dst = 5; mem_result = 32'h5A;
        expect_out("st_c2_fwd", 1, 0, 2'b00, 2'b11, 0, 32'h5A, WR);
        tick();
        clear_fwd();
        expect_out("st_c3", 1, 0, 2'b00, 2'b01, 0, 0, WR);
        tick();
        expect_out("st_done", 0, 0, 2'b00, 2'b01, 0, 0, RD);
        tick();

        // branch aborts a store stall
        store = 1;
        expect_out("ab_st", 1, 0, 2'b00, 2'b01, 0, 0, WR);
        tick();
        store = 0; branch = 1;
        expect_out("ab_br", 0, 1, 2'b00, 2'b01, 0, 0, RD);
        tick();
        branch = 0;
        expect_out("ab_fl2", 0, 1, 2'b00, 2'b01, 0, 0, RD);
        tick();
        expect_out("ab_idle", 0, 0, 2'b00, 2'b01, 0, 0, RD);
        tick();

        // branch beats store; store during flush ignored
        branch = 1; store = 1;
        expect_out("pri_c1", 0, 1, 2'b00, 2'b01, 0, 0, RD);
        tick();
        branch = 0;
        expect_out("pri_c2", 0, 1, 2'b00, 2'b01, 0, 0, RD);
        tick();
        store = 0;
        expect_out("pri_idle", 0, 0, 2'b00, 2'b01, 0, 0, RD);
        tick();

        // reset during a flush drops it immediately
        branch = 1;
        expect_out("rf_c1", 0, 1, 2'b00, 2'b01, 0, 0, RD);
        tick();
        branch = 0;
        #1 rst = 1'b1;
        expect_out("rf_rst", 0, 0, 2'b00, 2'b01, 0, 0, RD);
        tick();
        rst = 1'b0;
        expect_out("rf_idle", 0, 0, 2'b00, 2'b01, 0, 0, RD);
        tick();

        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
